// File: rtl/sevenseg_multi_display_if.sv
// Bundle of value/control inputs and segment/status outputs for the
// multi-digit seven-segment display controller.
interface sevenseg_multi_display_if #(
    parameter int NDIGITS = 6,
    parameter int WIDTH   = 20
);
    logic [WIDTH-1:0]     value;
    logic                 load;
    logic                 mode_dec;
    logic                 blank_lz;
    logic [NDIGITS-1:0]   blink_mask;
    logic [7*NDIGITS-1:0] seg;
    logic                 busy;
    logic                 done;
    logic                 ovf;

    modport master (
        output value, load, mode_dec, blank_lz, blink_mask,
        input  seg, busy, done, ovf
    );

    modport slave (
        input  value, load, mode_dec, blank_lz, blink_mask,
        output seg, busy, done, ovf
    );
endinterface

// File: rtl/sevenseg_multi_display.sv
// Multi-digit seven-segment controller: captures a value on load and shows it in hex
// or unsigned decimal (sequential double-dabble), with zero blanking, overflow and blink.
module sevenseg_multi_display #(
    parameter int NDIGITS   = 6,
    parameter int WIDTH     = 20,
    parameter int BLINK_DIV = 25000000
) (
    input logic                     clock,
    input logic                     resetn,
    sevenseg_multi_display_if.slave bus
);
    localparam int SEGW = 7 * NDIGITS;
    localparam int BCDW = 4 * NDIGITS;
    localparam int EXTW = (WIDTH > BCDW) ? WIDTH : BCDW;
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam int DIVW = $clog2(BLINK_DIV);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  val_q;
    logic              dec_q;
    logic              blz_q;
    logic [BCDW-1:0]   bcd_q;
    logic [BCDW-1:0]   bcd_adj;
    logic              conv_ovf_q;
    logic [CNTW-1:0]   step_q;
    logic              last_step;
    logic [SEGW-1:0]   seg_q;
    logic [SEGW-1:0]   pattern;
    logic [SEGW-1:0]   seg_out;
    logic              done_q;
    logic              ovf_q;
    logic [DIVW-1:0]   blink_cnt;
    logic              phase;
    logic [EXTW-1:0]   val_ext;
    logic [BCDW-1:0]   digits;
    logic              hex_ovf;
    logic              show_ovf;
    logic              zero_above;

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'h0: encode = 7'b1000000;
            4'h1: encode = 7'b1111001;
            4'h2: encode = 7'b0100100;
            4'h3: encode = 7'b0110000;
            4'h4: encode = 7'b0011001;
            4'h5: encode = 7'b0010010;
            4'h6: encode = 7'b0000010;
            4'h7: encode = 7'b1111000;
            4'h8: encode = 7'b0000000;
            4'h9: encode = 7'b0010000;
            4'hA: encode = 7'b0001000;
            4'hB: encode = 7'b0000011;
            4'hC: encode = 7'b1000110;
            4'hD: encode = 7'b0100001;
            4'hE: encode = 7'b0000110;
            default: encode = 7'b0001110;
        endcase
    endfunction

    assign last_step = (step_q == CNTW'(WIDTH - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.load) state_next = bus.mode_dec ? CONV : WRITE;
            CONV:    if (last_step) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            val_q      <= '0;
            dec_q      <= 1'b0;
            blz_q      <= 1'b0;
            bcd_q      <= '0;
            conv_ovf_q <= 1'b0;
            step_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        val_q      <= bus.value;
                        dec_q      <= bus.mode_dec;
                        blz_q      <= bus.blank_lz;
                        bcd_q      <= '0;
                        conv_ovf_q <= 1'b0;
                        step_q     <= '0;
                    end
                end
                CONV: begin
                    bcd_q  <= {bcd_adj[BCDW-2:0], val_q[WIDTH-1]};
                    val_q  <= val_q << 1;
                    step_q <= step_q + 1'b1;
                    if (bcd_adj[BCDW-1]) conv_ovf_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // val_q is only intact on the hex path; the decimal path shifts it away.
    always_comb begin
        val_ext    = EXTW'(val_q);
        hex_ovf    = ((val_ext >> BCDW) != '0);
        digits     = dec_q ? bcd_q : val_ext[BCDW-1:0];
        show_ovf   = dec_q ? conv_ovf_q : hex_ovf;
        pattern    = '1;
        zero_above = 1'b1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (digits[4*i +: 4] == 4'd0);
            if (show_ovf)                          pattern[7*i +: 7] = SEG_DASH;
            else if (blz_q && i != 0 && zero_above) pattern[7*i +: 7] = SEG_BLANK;
            else                                   pattern[7*i +: 7] = encode(digits[4*i +: 4]);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            seg_q  <= '1;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= (state == WRITE);
            if (state == WRITE) begin
                seg_q <= pattern;
                ovf_q <= show_ovf;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == DIVW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Blink masking stays combinational so blink_mask changes show up at once.
    always_comb begin
        seg_out = seg_q;
        for (int i = 0; i < NDIGITS; i++) begin
            if (phase && bus.blink_mask[i]) seg_out[7*i +: 7] = SEG_BLANK;
        end
    end

    assign bus.seg  = seg_out;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_sevenseg_multi_display.sv
// Bench for sevenseg_multi_display: directed loads checked against hand-computed patterns
// and against an arithmetic model of the display compared every cycle.
module tb_sevenseg_multi_display;
    localparam int ND   = 6;
    localparam int W    = 20;
    localparam int BDIV = 4;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] ENC [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    sevenseg_multi_display_if #(.NDIGITS(ND), .WIDTH(W)) bus ();

    sevenseg_multi_display #(.NDIGITS(ND), .WIDTH(W), .BLINK_DIV(BDIV)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Digits come from repeated division by the radix; overflow is whatever is left over.
    function automatic logic [7*ND-1:0] render(input int unsigned v, input bit dec, input bit blz, output bit of);
        int unsigned base = dec ? 10 : 16;
        int unsigned rest = v;
        int unsigned d [ND];
        int          sig = 1;
        logic [7*ND-1:0] r;
        for (int i = 0; i < ND; i++) begin
            d[i] = rest % base;
            rest = rest / base;
            if (d[i] != 0) sig = i + 1;
        end
        of = (rest != 0);
        for (int i = 0; i < ND; i++) begin
            if (of)                 r[7*i +: 7] = DASH;
            else if (blz && i >= sig) r[7*i +: 7] = BLANK;
            else                    r[7*i +: 7] = ENC[d[i]];
        end
        return r;
    endfunction

    int              m_left = 0;
    int              m_cyc  = 0;
    logic [7*ND-1:0] m_held = '1;
    logic [7*ND-1:0] m_next = '1;
    bit              m_ovf = 0;
    bit              m_ovf_next = 0;
    bit              m_done = 0;
    logic [7*ND-1:0] exp_seg;
    bit              m_phase;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_left = 0;
            m_cyc  = 0;
            m_held = '1;
            m_ovf  = 0;
            m_done = 0;
        end else begin
            m_cyc++;
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_held = m_next;
                    m_ovf  = m_ovf_next;
                    m_done = 1;
                end
            end else if (bus.load === 1'b1) begin
                m_next = render(int'(bus.value), bus.mode_dec, bus.blank_lz, m_ovf_next);
                m_left = bus.mode_dec ? W + 1 : 1;
            end
        end
    end

    always @(negedge clock) begin
        #2;
        m_phase = ((m_cyc / BDIV) % 2) == 1;
        exp_seg = m_held;
        for (int i = 0; i < ND; i++) begin
            if (m_phase && bus.blink_mask[i] === 1'b1) exp_seg[7*i +: 7] = BLANK;
        end
        checkOutput("model_seg", bus.seg, exp_seg);
        checkOutput("model_busy", bus.busy, m_left > 0);
        checkOutput("model_done", bus.done, m_done);
        checkOutput("model_ovf", bus.ovf, m_ovf);
    end

    task automatic applyStimulus(input logic [W-1:0] v, input logic dec, input logic blz);
        @(negedge clock);
        bus.value    = v;
        bus.mode_dec = dec;
        bus.blank_lz = blz;
        bus.load     = 1'b1;
        @(negedge clock);
        bus.load     = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clock);
            lat++;
            if (bus.done === 1'b1) break;
        end
        checkOutput("done_seen", bus.done, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int n_done;
        int n_blank;
        int n_five;
        int n_upper_bad;
        bit found;

        bus.value      = '0;
        bus.load       = 1'b0;
        bus.mode_dec   = 1'b0;
        bus.blank_lz   = 1'b0;
        bus.blink_mask = '0;
        resetn         = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_seg", bus.seg, {7*ND{1'b1}});
        checkOutput("reset_busy", bus.busy, 1'b0);
        checkOutput("reset_done", bus.done, 1'b0);
        checkOutput("reset_ovf", bus.ovf, 1'b0);
        resetn = 1'b1;

        $display("[TB] hex 0x1234A with leading-zero blanking");
        applyStimulus(20'h1234A, 1'b0, 1'b1);
        checkOutput("hex_busy_after_load", bus.busy, 1'b1);
        waitDone(lat);
        checkOutput("hex_latency", lat, 1);
        checkOutput("hex_seg", bus.seg,
                    {BLANK, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0001000});
        checkOutput("hex_busy_done", bus.busy, 1'b0);
        checkOutput("hex_ovf", bus.ovf, 1'b0);

        $display("[TB] decimal zero, blanked and unblanked");
        applyStimulus(20'd0, 1'b1, 1'b1);
        waitDone(lat);
        checkOutput("dec0_latency", lat, W + 1);
        checkOutput("dec0_blz_seg", bus.seg, {{5{BLANK}}, 7'b1000000});
        applyStimulus(20'd0, 1'b1, 1'b0);
        waitDone(lat);
        checkOutput("dec0_seg", bus.seg, {6{7'b1000000}});

        $display("[TB] decimal 123 with an ignored load during conversion");
        applyStimulus(20'd123, 1'b1, 1'b1);
        n_done = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (bus.done === 1'b1) n_done++;
            if (k == 4) begin
                bus.value = 20'hFFFFF;
                bus.load  = 1'b1;
            end else begin
                bus.load  = 1'b0;
            end
        end
        checkOutput("ignored_load_done_count", n_done, 1);
        checkOutput("dec123_seg", bus.seg, {BLANK, BLANK, BLANK, 7'b1111001, 7'b0100100, 7'b0110000});

        $display("[TB] decimal 999999 and 1000000");
        applyStimulus(20'd999999, 1'b1, 1'b0);
        waitDone(lat);
        checkOutput("dec999999_latency", lat, W + 1);
        checkOutput("dec999999_seg", bus.seg, {6{7'b0010000}});
        checkOutput("dec999999_ovf", bus.ovf, 1'b0);
        applyStimulus(20'd1000000, 1'b1, 1'b0);
        waitDone(lat);
        checkOutput("dec_ovf_seg", bus.seg, {6{DASH}});
        checkOutput("dec_ovf_flag", bus.ovf, 1'b1);

        $display("[TB] reset during conversion");
        applyStimulus(20'd777, 1'b1, 1'b0);
        repeat (9) @(negedge clock);
        checkOutput("ovf_held_in_conv", bus.ovf, 1'b1);
        #4;
        resetn = 1'b0;
        #1;
        checkOutput("midreset_seg", bus.seg, {7*ND{1'b1}});
        checkOutput("midreset_busy", bus.busy, 1'b0);
        checkOutput("midreset_ovf", bus.ovf, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        applyStimulus(20'd5, 1'b0, 1'b0);
        waitDone(lat);
        checkOutput("post_reset_latency", lat, 1);
        checkOutput("post_reset_seg", bus.seg, {{5{7'b1000000}}, 7'b0010010});

        $display("[TB] blink on digit 0");
        @(negedge clock);
        bus.blink_mask = 6'b000001;
        n_blank = 0;
        n_five = 0;
        n_upper_bad = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            #1;
            if (bus.seg[6:0] === BLANK) n_blank++;
            if (bus.seg[6:0] === 7'b0010010) n_five++;
            if (bus.seg[7*ND-1:7] !== {5{7'b1000000}}) n_upper_bad++;
        end
        checkOutput("blink_blank_cycles", n_blank, 8);
        checkOutput("blink_shown_cycles", n_five, 8);
        checkOutput("blink_upper_steady", n_upper_bad, 0);

        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clock);
            #1;
            if (bus.seg[6:0] === BLANK) found = 1;
        end
        checkOutput("blink_phase_found", found, 1'b1);
        #2;
        bus.blink_mask = '0;
        #1;
        checkOutput("blink_mask_immediate", bus.seg[6:0], 7'b0010010);

        repeat (3) @(negedge clock);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
